// File: rtl/mem_loader.sv
// Streams a full 2^AddressSize-word image from a valid/ready host into program memory.
// Latency 1 cycle from acceptance to MEM_WE; backpressure: in_ready is high only in LOAD (one word per 2 cycles).
module mem_loader #(
    parameter int WordSize    = 8,
    parameter int AddressSize = 4
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   start,
    input  logic [WordSize-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [AddressSize-1:0] MEM_address,
    output logic [WordSize-1:0]    MEM_data,
    output logic                   MEM_WE,
    output logic                   prog_mode,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   last_word;
    logic [AddressSize-1:0] counter;
    logic [AddressSize-1:0] addr_q;
    logic [WordSize-1:0]    word_q;

    assign last_word   = (counter == {AddressSize{1'b1}});
    assign MEM_address = addr_q;
    assign MEM_data    = word_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        MEM_WE    = 1'b0;
        prog_mode = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready  = 1'b1;
                prog_mode = 1'b1;
                accept    = in_valid;
                if (in_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                MEM_WE    = 1'b1;
                prog_mode = 1'b1;
                state_nxt = last_word ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                prog_mode = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address and data are latched at acceptance so they are already stable
    // during the WRITE cycle, and simply hold afterwards.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            counter <= '0;
            addr_q  <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                addr_q <= counter;
                word_q <= in_data;
            end
            if (state == WRITE) begin
                counter <= counter + 1'b1;
            end else if (state == IDLE && start) begin
                counter <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed vector table plus hand-written load, gapped, start-ignore and abort sequences.
module tb_mem_loader;

    logic       CLK;
    logic       CLR;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] MEM_address;
    logic [7:0] MEM_data;
    logic       MEM_WE;
    logic       prog_mode;
    logic       done;

    int tests;
    int fails;

    mem_loader #(.WordSize(8), .AddressSize(4)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .MEM_address (MEM_address),
        .MEM_data    (MEM_data),
        .MEM_WE      (MEM_WE),
        .prog_mode   (prog_mode),
        .done        (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       clr;
        logic       st;
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic       we;
        logic       prog;
        logic       dn;
        logic [3:0] addr;
        logic [7:0] mdat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, sample outputs 1 time unit after the rising edge.
    task automatic step(input logic c, input logic s, input logic v, input logic [7:0] d);
        @(negedge CLK);
        CLR      = c;
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {in_ready, MEM_WE, prog_mode, done, MEM_address, MEM_data};
    endfunction

    task automatic drive_load(input logic [7:0] base, input bit gapped, input int start_word);
        int   writes;
        int   acc_cnt;
        int   last_we;
        bit   acc_prev;
        bit   pulsed;
        bit   fin;
        logic v;
        logic s;
        writes  = 0;
        acc_cnt = 0;
        last_we = -10;
        pulsed  = 0;
        fin     = 0;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("start_enters_load", 32'({in_ready, prog_mode, MEM_WE}), 32'h6);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            s = 1'b0;
            if (start_word >= 0 && !pulsed && in_ready && acc_cnt == start_word) begin
                s      = 1'b1;
                pulsed = 1;
            end
            acc_prev = in_ready && v;
            step(1'b0, s, v, base + 8'(acc_cnt));
            if (acc_prev) acc_cnt++;
            if (MEM_WE) begin
                chk("we_follows_accept", 32'(acc_prev), 32'd1);
                chk("we_addr", 32'(MEM_address), 32'(writes % 16));
                chk("we_data", 32'(MEM_data), 32'(8'(base + 8'(writes))));
                if (!gapped && writes > 0) chk("we_spacing", 32'(cyc - last_we), 32'd2);
                last_we = cyc;
                writes++;
            end else if (acc_prev) begin
                chk("we_missing", 32'd0, 32'd1);
            end
            if (done) begin
                chk("done_write_count", 32'(writes), 32'd16);
                chk("done_latency", 32'(cyc - last_we), 32'd1);
                chk("done_prog_mode", 32'(prog_mode), 32'd1);
                fin = 1;
            end else if (!prog_mode) begin
                chk("prog_mode_dropped", 32'd0, 32'd1);
            end
        end
        if (!fin) chk("load_timeout", 32'd0, 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h66);
        chk("idle_after_done", 32'({done, prog_mode, in_ready, MEM_WE}), 32'd0);
    endtask

    initial begin
        int   acc;
        bit   hit;
        bit   acc_now;
        tests    = 0;
        fails    = 0;
        CLR      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //           clr   st    vld   dat     rdy   we    prog  dn    addr  mdat
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h10};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h10};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h10};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 8'h11};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 8'h12};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].clr, vecs[i].st, vecs[i].vld, vecs[i].dat);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].rdy, vecs[i].we, vecs[i].prog, vecs[i].dn, vecs[i].addr, vecs[i].mdat}));
        end

        drive_load(8'h10, 1'b0, -1);
        drive_load(8'hA0, 1'b1, -1);
        drive_load(8'h40, 1'b0, 7);

        // Abort in the WRITE cycle of word 5, then restart from address 0.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        acc = 0;
        hit = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            acc_now = in_ready;
            step(1'b0, 1'b0, 1'b1, 8'hC0 + 8'(acc));
            if (acc_now) acc++;
            if (MEM_WE && MEM_address == 4'd5) hit = 1;
        end
        chk("abort_reached_word5", 32'({hit, MEM_data}), 32'h1C5);
        step(1'b1, 1'b0, 1'b1, 8'hEE);
        chk("abort_all_zero", 32'(outs()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE);
            chk("abort_no_more_we", 32'({MEM_WE, prog_mode, in_ready}), 32'd0);
        end
        drive_load(8'h30, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WordSize, default 8, width of each memory word written.
REQ-002 Parameter AddressSize, default 4, memory address width; the image holds 2^AddressSize words.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 CLR  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin loading a full memory image.
REQ-006 in_data  input  WordSize  next image word from the host.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  loader accepts a word this cycle.
REQ-009 MEM_address  output  AddressSize  write address to program memory.
REQ-010 MEM_data  output  WordSize  write data to program memory.
REQ-011 MEM_WE  output  1  active-high memory write strobe, one cycle per word.
REQ-012 prog_mode  output  1  high while loading; holds the CPU off the memory bus.
REQ-013 done  output  1  one-cycle pulse when the full image has been written.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WRITE and DONE.
REQ-015 IDLE: in_ready=0, MEM_WE=0, prog_mode=0; start=1 SHALL move to LOAD with address counter cleared to 0.
REQ-016 LOAD: in_ready=1, prog_mode=1; on in_valid&&in_ready the FSM SHALL capture in_data and move to WRITE next cycle; otherwise it stays in LOAD indefinitely.
REQ-017 WRITE: MEM_WE=1, MEM_address=counter, MEM_data=captured word, in_ready=0, prog_mode=1, for exactly one cycle.
REQ-018 At the end of WRITE the counter SHALL increment modulo 2^AddressSize; if the pre-increment value was 2^AddressSize-1 the next state SHALL be DONE, else LOAD.
REQ-019 DONE: done=1, prog_mode=1, MEM_WE=0 for one cycle, then IDLE (counter is 0 after wrap).
REQ-020 Write latency SHALL be exactly 1 cycle from acceptance to MEM_WE; peak throughput is one word per 2 cycles.
REQ-021 start SHALL be ignored in LOAD, WRITE and DONE.
REQ-022 in_valid SHALL be ignored (no capture, no write) in IDLE, WRITE and DONE.
REQ-023 MEM_address and MEM_data SHALL hold their last values outside WRITE; only MEM_WE qualifies a write.
REQ-024 Words SHALL be written at consecutive addresses 0..2^AddressSize-1 in acceptance order; no address is skipped or repeated.

Reset
REQ-025 CLR=1 SHALL force IDLE, counter=0, captured word=0, MEM_address=0, MEM_data=0, MEM_WE=0, in_ready=0, prog_mode=0, done=0 at the next edge.
REQ-026 CLR SHALL take priority over start and in_valid in the same cycle.
REQ-027 CLR during LOAD or WRITE SHALL abort the load with no further MEM_WE; a partial image is not rolled back.

Verification
REQ-028 Reset: CLR=1 for 2 cycles with start=1 and in_valid=1 -> all outputs 0, state IDLE.
REQ-029 Full load: start, then in_valid held high with words 0x10..0x1F -> 16 MEM_WE pulses at addresses 0..15 carrying 0x10..0x1F, each 1 cycle after acceptance, spaced 2 cycles apart; done pulses once 1 cycle after the last write; prog_mode high from the cycle after start through DONE.
REQ-030 Gapped input: in_valid toggled randomly with words 0xA0..0xAF -> same address/data pairing, no extra or missing MEM_WE.
REQ-031 Ignored inputs: in_valid=1 with 0x55 in IDLE -> no MEM_WE; start pulse during LOAD at word 7 -> counter not cleared, load completes normally.
REQ-032 Abort: CLR asserted in the WRITE cycle of word 5 -> that MEM_WE is the last, next cycle all outputs 0; a new start then writes from address 0.
